// File: rtl/moore_fsm_pkg.sv
// Shared types and code constants for the moore_fsm ordered-sequence tracker.
package moore_fsm_pkg;

  // State encoding doubles as the output code, so out is a direct decode.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S2   = 2'b10,
    S3   = 2'b11
  } state_t;

  typedef logic [1:0] code_t;

  localparam code_t CODE_NONE  = 2'b00;
  localparam code_t CODE_STEP1 = 2'b01;
  localparam code_t CODE_STEP2 = 2'b10;
  localparam code_t CODE_STEP3 = 2'b11;

  // Width of the idle counter; TIMEOUT_CYCLES must fit in it.
  localparam int unsigned TIMER_W = 8;

  // Table-driven next state, ignoring any timeout.
  function automatic state_t seq_next(input state_t cur, input code_t code);
    state_t nxt;
    nxt = IDLE;
    case (code)
      CODE_NONE: nxt = cur;
      // 01 always (re)starts the sequence, from any state.
      CODE_STEP1: nxt = S1;
      CODE_STEP2: nxt = (cur == S1) ? S2 : IDLE;
      CODE_STEP3: nxt = (cur == S2) ? S3 : IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/moore_fsm_timer.sv
// Idle counter for moore_fsm: counts consecutive idle cycles and flags when
// the programmed limit has been reached. Used only with MOORE_FSM_TIMEOUT_EN.
module moore_fsm_timer
  import moore_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  // Counter register: clear has priority over increment; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TIMER_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/moore_fsm.sv
// Moore ordered-sequence tracker: IDLE->S1->S2->S3 on codes 01,10,11.
// Optional idle timeout enabled with `define MOORE_FSM_TIMEOUT_EN.
module moore_fsm
  import moore_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  output logic [1:0] out
);

  // Elaboration-time range check on the timeout limit.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("moore_fsm: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t state;
  state_t state_nxt;
  code_t  code;

  assign code = code_t'(in);

`ifdef MOORE_FSM_TIMEOUT_EN
  logic tmr_clr;
  logic tmr_inc;
  logic tmr_expired;
  logic timeout_hit;

  // Timer control: count idle cycles outside IDLE, clear on activity or timeout.
  always_comb begin
    timeout_hit = tmr_expired && (code == CODE_NONE) && (state != IDLE);
    tmr_clr     = (code != CODE_NONE) || (state == IDLE) || timeout_hit;
    tmr_inc     = !tmr_clr;
  end

  moore_fsm_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expired(tmr_expired)
  );
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: sequence table, with optional idle timeout override.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, S1, S2, S3: state_nxt = seq_next(state, code);
      default:          state_nxt = IDLE;
    endcase
`ifdef MOORE_FSM_TIMEOUT_EN
    if (timeout_hit) begin
      state_nxt = IDLE;
    end
`endif
  end

  // Output decode from the state register only.
  always_comb begin
    out = 2'b00;
    case (state)
      IDLE:    out = 2'b00;
      S1:      out = 2'b01;
      S2:      out = 2'b10;
      S3:      out = 2'b11;
      default: out = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_moore_fsm.sv
// Scoreboard bench for moore_fsm: stimulus pushes expected out per edge,
// monitor pops and compares one time unit after each rising edge.
module tb_moore_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] in;
  logic [1:0] out;

  typedef struct {
    logic [1:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        stim_done = 1'b0;

  moore_fsm #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge worth of inputs and queue the out expected after that edge.
  task automatic apply(input logic r, input logic [1:0] c, input logic [1:0] e,
                       input string name);
    sb_item_t it;
    @(negedge clk);
    reset = r;
    in    = c;
    it.exp  = e;
    it.name = name;
    sbq.push_back(it);
  endtask

  // Monitor: out is valid every cycle, so compare one item per edge.
  initial begin
    sb_item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        checks++;
        if (out !== it.exp) begin
          errors++;
          $display("FAIL %s: out=%b expected=%b", it.name, out, it.exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    in    = 2'b00;

    // 1. reset and quiet hold
    apply(1, 2'b00, 2'b00, "reset");
    for (int i = 0; i < 4; i++) apply(0, 2'b00, 2'b00, "idle_hold");

    // 2. full sequence then hold in S3
    apply(0, 2'b01, 2'b01, "seq_s1a");
    apply(0, 2'b01, 2'b01, "seq_s1b_held");
    apply(0, 2'b10, 2'b10, "seq_s2");
    apply(0, 2'b11, 2'b11, "seq_s3");
    for (int i = 0; i < 3; i++) apply(0, 2'b00, 2'b11, "s3_sticky");

    // 3. single-cycle pulses from S3
    apply(0, 2'b01, 2'b01, "pulse_s1");
    apply(0, 2'b00, 2'b01, "pulse_hold1");
    apply(0, 2'b10, 2'b10, "pulse_s2");
    apply(0, 2'b00, 2'b10, "pulse_hold2");
    apply(0, 2'b11, 2'b11, "pulse_s3");
    apply(0, 2'b00, 2'b11, "pulse_hold3");

    // S3 aborts on 10 and 11
    apply(0, 2'b10, 2'b00, "s3_abort10");
    apply(0, 2'b01, 2'b01, "to_s1");
    apply(0, 2'b10, 2'b10, "to_s2");
    apply(0, 2'b11, 2'b11, "to_s3");
    apply(0, 2'b11, 2'b00, "s3_abort11");

    // 4. out-of-order codes
    apply(0, 2'b10, 2'b00, "idle_10");
    apply(0, 2'b11, 2'b00, "idle_11");
    apply(0, 2'b01, 2'b01, "idle_01");
    apply(0, 2'b11, 2'b00, "s1_11");
    apply(0, 2'b01, 2'b01, "to_s1b");
    apply(0, 2'b10, 2'b10, "to_s2b");
    apply(0, 2'b01, 2'b01, "s2_01");
    apply(0, 2'b10, 2'b10, "to_s2c");
    apply(0, 2'b10, 2'b00, "s2_10_held");

    // 5. reset wins over in=11 from S2
    apply(0, 2'b01, 2'b01, "r_s1");
    apply(0, 2'b10, 2'b10, "r_s2");
    apply(1, 2'b11, 2'b00, "reset_wins");
    apply(0, 2'b00, 2'b00, "after_reset");

`ifdef MOORE_FSM_TIMEOUT_EN
    // 6. timeout after 8 idle edges in S3
    apply(0, 2'b01, 2'b01, "t_s1");
    apply(0, 2'b10, 2'b10, "t_s2");
    apply(0, 2'b11, 2'b11, "t_s3");
    for (int i = 0; i < 8; i++) apply(0, 2'b00, 2'b11, "t_hold");
    apply(0, 2'b00, 2'b00, "t_expire");
    // activity on the 5th idle cycle restarts the count
    apply(0, 2'b01, 2'b01, "t2_s1");
    apply(0, 2'b10, 2'b10, "t2_s2");
    apply(0, 2'b11, 2'b11, "t2_s3");
    for (int i = 0; i < 4; i++) apply(0, 2'b00, 2'b11, "t2_hold");
    apply(0, 2'b01, 2'b01, "t2_restart");
    for (int i = 0; i < 8; i++) apply(0, 2'b00, 2'b01, "t2_hold_s1");
    apply(0, 2'b00, 2'b00, "t2_expire");
`else
    // without the timeout, S3 holds indefinitely
    apply(0, 2'b01, 2'b01, "n_s1");
    apply(0, 2'b10, 2'b10, "n_s2");
    apply(0, 2'b11, 2'b11, "n_s3");
    for (int i = 0; i < 20; i++) apply(0, 2'b00, 2'b11, "n_hold");
`endif

    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then summarise.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
